// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-compatible interrupt controller:
// OCW2 command codes, acknowledge FSM states and rotation helpers.
package pic_pkg;

  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] OCW2_NOP     = 3'b010;
  localparam logic [2:0] EOI_SPEC     = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] SET_PRIO     = 3'b110;
  localparam logic [2:0] ROT_SPEC_EOI = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    ACK2 = 1'b1
  } pic_state_e;

  // Rotations act on the low n bits only; sh must be below n.
  function automatic logic [31:0] rot_right(input logic [31:0] v, input int unsigned n,
                                            input int unsigned sh);
    logic [31:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = i + sh;
        if (idx >= n) idx = idx - n;
        r[i] = v[idx[4:0]];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_left(input logic [31:0] v, input int unsigned n,
                                           input int unsigned sh);
    logic [31:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = i + n - sh;
        if (idx >= n) idx = idx - n;
        r[i] = v[idx[4:0]];
      end
    end
    return r;
  endfunction

  // Distance of lvl below the highest-priority level; 0 is highest priority.
  function automatic int unsigned prio_rank(input int unsigned lvl, input int unsigned high,
                                            input int unsigned n);
    return (lvl >= high) ? (lvl - high) : (lvl + n - high);
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational rotating priority encoder: finds the highest-priority set bit
// of vec, where the level after lowest_prio is the highest priority.
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int LVL_W = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [LVL_W-1:0]   lowest_prio,
  output logic               found,
  output logic [LVL_W-1:0]   level
);

  logic [LVL_W-1:0]   high;
  logic [LVL_W-1:0]   rank;
  logic [NUM_IRQ-1:0] rot;
  logic [LVL_W:0]     sum;

  always_comb begin
    high  = (lowest_prio == LVL_W'(NUM_IRQ - 1)) ? '0 : lowest_prio + 1'b1;
    rot   = NUM_IRQ'(rot_right(32'(vec), NUM_IRQ, 32'(high)));
    found = |vec;
    rank  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rot[i]) rank = LVL_W'(i);
    end
    sum = (LVL_W+1)'(high) + (LVL_W+1)'(rank);
    if (sum >= (LVL_W+1)'(NUM_IRQ)) sum = sum - (LVL_W+1)'(NUM_IRQ);
    level = sum[LVL_W-1:0];
  end

endmodule

// File: rtl/isr_priority_ctrl.sv
// In-service register, rotating-priority arbitration, INTA two-pulse sequencing
// and OCW2 command execution for the 8259A-compatible interrupt controller.
module isr_priority_ctrl
  import pic_pkg::*;
#(
  parameter int NUM_IRQ      = 8,
  parameter int SPURIOUS_LVL = NUM_IRQ - 1,
  localparam int LVL_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               special_mask_mode,
  input  logic               aeoi_mode,
  input  logic               inta_pulse,
  input  logic               ocw2_valid,
  input  logic [2:0]         ocw2_cmd,
  input  logic [LVL_W-1:0]   ocw2_level,
  output logic [NUM_IRQ-1:0] isr,
  output logic               int_req,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic               vector_valid,
  output logic [LVL_W-1:0]   vector_level,
  output logic [LVL_W-1:0]   lowest_prio
);

  pic_state_e         state;
  logic [LVL_W-1:0]   lat_lvl;
  logic               lat_spur;
  logic               rotate_aeoi;

  logic [NUM_IRQ-1:0] blk_vec;
  logic [LVL_W-1:0]   high;
  logic               irr_found, blk_found, isr_found;
  logic [LVL_W-1:0]   irr_lvl, blk_lvl, isr_lvl;

  logic               win, ack2_strobe, aeoi_hit, lvl_ok;
  logic [NUM_IRQ-1:0] win_onehot, eoi_clr, aeoi_clr, isr_nxt;
  logic               lp_wr, rot_wr, rot_val;
  logic [LVL_W-1:0]   lp_val;

  assign blk_vec = special_mask_mode ? (isr & ~imr) : isr;
  assign high    = (lowest_prio == LVL_W'(NUM_IRQ - 1)) ? '0 : lowest_prio + 1'b1;

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_irr_res (
    .vec(irr), .lowest_prio(lowest_prio), .found(irr_found), .level(irr_lvl));

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_blk_res (
    .vec(blk_vec), .lowest_prio(lowest_prio), .found(blk_found), .level(blk_lvl));

  // Non-specific EOI targets the full ISR, independent of special mask mode.
  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
    .vec(isr), .lowest_prio(lowest_prio), .found(isr_found), .level(isr_lvl));

  always_comb begin
    win = irr_found && (!blk_found ||
          (prio_rank(32'(irr_lvl), 32'(high), NUM_IRQ) <
           prio_rank(32'(blk_lvl), 32'(high), NUM_IRQ)));

    win_onehot = '0;
    if (state == IDLE && inta_pulse && win) win_onehot[irr_lvl] = 1'b1;

    ack2_strobe = (state == ACK2) && inta_pulse;
    aeoi_hit    = ack2_strobe && aeoi_mode && !lat_spur;
    aeoi_clr    = '0;
    if (aeoi_hit) aeoi_clr[lat_lvl] = 1'b1;

    eoi_clr = '0;
    lp_wr   = 1'b0;
    lp_val  = lowest_prio;
    rot_wr  = 1'b0;
    rot_val = rotate_aeoi;
    lvl_ok  = 32'(ocw2_level) < NUM_IRQ;
    if (ocw2_valid && lvl_ok) begin
      case (ocw2_cmd)
        EOI_NS:       if (isr_found) eoi_clr[isr_lvl] = 1'b1;
        EOI_SPEC:     eoi_clr[ocw2_level] = 1'b1;
        ROT_NS_EOI: begin
          if (isr_found) begin
            eoi_clr[isr_lvl] = 1'b1;
            lp_wr  = 1'b1;
            lp_val = isr_lvl;
          end
        end
        ROT_SPEC_EOI: begin
          eoi_clr[ocw2_level] = 1'b1;
          lp_wr  = 1'b1;
          lp_val = ocw2_level;
        end
        SET_PRIO: begin
          lp_wr  = 1'b1;
          lp_val = ocw2_level;
        end
        ROT_AEOI_SET: begin rot_wr = 1'b1; rot_val = 1'b1; end
        ROT_AEOI_CLR: begin rot_wr = 1'b1; rot_val = 1'b0; end
        default: ;
      endcase
    end

    // Clears see the pre-update ISR; a same-cycle acknowledge set wins.
    isr_nxt = (isr & ~eoi_clr & ~aeoi_clr) | win_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      isr          <= '0;
      int_req      <= 1'b0;
      irr_clear    <= '0;
      vector_valid <= 1'b0;
      vector_level <= '0;
      lowest_prio  <= LVL_W'(NUM_IRQ - 1);
      rotate_aeoi  <= 1'b0;
      lat_lvl      <= '0;
      lat_spur     <= 1'b0;
    end else begin
      isr          <= isr_nxt;
      irr_clear    <= win_onehot;
      vector_valid <= 1'b0;
      if (rot_wr) rotate_aeoi <= rot_val;
      if (lp_wr) lowest_prio <= lp_val;
      else if (aeoi_hit && rotate_aeoi) lowest_prio <= lat_lvl;
      case (state)
        IDLE: begin
          if (inta_pulse) begin
            int_req  <= 1'b0;
            lat_lvl  <= win ? irr_lvl : LVL_W'(SPURIOUS_LVL);
            lat_spur <= !win;
            state    <= ACK2;
          end else begin
            int_req <= win;
          end
        end
        ACK2: begin
          int_req <= 1'b0;
          if (inta_pulse) begin
            vector_valid <= 1'b1;
            vector_level <= lat_lvl;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
